// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute controller driving the PC register's hold/jump inputs, with a return-address stack.
// Define PCSEQ_PERF_EN to add the saturating perf_retired/perf_stall counters.
module pc_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc_in,
    input  logic            fetch_ack,
    input  logic            exec_stall,
    input  logic            dec_jump,
    input  logic            dec_branch,
    input  logic            branch_taken,
    input  logic            dec_call,
    input  logic            dec_ret,
    input  logic            dec_halt,
    input  logic [PC_W-1:0] dec_target,
    input  logic            resume,
    output logic            fetch_req,
    output logic            pc_hold,
    output logic            pc_jump,
    output logic [PC_W-1:0] pc_jump_line,
    output logic            retire,
    output logic            halted,
    output logic            stack_err
`ifdef PCSEQ_PERF_EN
    ,
    output logic [15:0]     perf_retired,
    output logic [15:0]     perf_stall
`endif
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int SW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    state_t          r_state, w_next;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];
    logic [SW-1:0]   r_sp;
    logic            r_err;
    logic            w_push, w_pop, w_err, w_take;
    logic [AW-1:0]   w_top;

    assign w_top     = AW'(r_sp - 1'b1);
    assign w_take    = dec_jump | (dec_branch & branch_taken);
    assign stack_err = r_err;

    // Decoder flags only matter in the final (non-stalled) EXEC cycle.
    always_comb begin
        w_next       = r_state;
        fetch_req    = 1'b0;
        pc_hold      = 1'b1;
        pc_jump      = 1'b0;
        pc_jump_line = '0;
        retire       = 1'b0;
        halted       = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                fetch_req = 1'b1;
                if (fetch_ack) w_next = S_EXEC;
            end
            S_EXEC: if (!exec_stall) begin
                if (dec_halt) begin
                    retire = 1'b1;
                    w_next = S_HALT;
                end else if (dec_ret && r_sp == '0) begin
                    w_err  = 1'b1;
                    w_next = S_HALT;
                end else if (dec_ret) begin
                    pc_hold      = 1'b0;
                    pc_jump      = 1'b1;
                    pc_jump_line = r_stack[w_top];
                    w_pop        = 1'b1;
                    retire       = 1'b1;
                    w_next       = S_FETCH;
                end else if (dec_call && r_sp == SW'(STACK_DEPTH)) begin
                    w_err  = 1'b1;
                    w_next = S_HALT;
                end else if (dec_call) begin
                    pc_hold      = 1'b0;
                    pc_jump      = 1'b1;
                    pc_jump_line = dec_target;
                    w_push       = 1'b1;
                    retire       = 1'b1;
                    w_next       = S_FETCH;
                end else begin
                    pc_hold      = 1'b0;
                    pc_jump      = w_take;
                    pc_jump_line = w_take ? dec_target : '0;
                    retire       = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            default: begin
                halted = 1'b1;
                if (resume && !r_err) w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sp    <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_err) r_err <= 1'b1;
            if (w_push) begin
                r_stack[r_sp[AW-1:0]] <= pc_in + 1'b1;
                r_sp                  <= r_sp + 1'b1;
            end else if (w_pop) begin
                r_sp <= r_sp - 1'b1;
            end
        end
    end

`ifdef PCSEQ_PERF_EN
    logic w_stall_cyc;
    assign w_stall_cyc = (r_state == S_FETCH && !fetch_ack) || (r_state == S_EXEC && exec_stall);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (retire && perf_retired != 16'hFFFF) perf_retired <= perf_retired + 1'b1;
            if (w_stall_cyc && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized instruction streams checked against an instruction-level model
// (PC arithmetic plus a queue as the return stack) that also plays the role of the PC register.
module tb_pc_sequencer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic [7:0] pc_in = '0, dec_target = '0;
    logic       fetch_ack = 1'b1, exec_stall = 1'b0, resume = 1'b0;
    logic       dec_jump = 1'b0, dec_branch = 1'b0, branch_taken = 1'b0;
    logic       dec_call = 1'b0, dec_ret = 1'b0, dec_halt = 1'b0;
    logic       fetch_req, pc_hold, pc_jump, retire, halted, stack_err;
    logic [7:0] pc_jump_line;
`ifdef PCSEQ_PERF_EN
    logic [15:0] perf_retired, perf_stall;
`endif

    int         checks = 0, errors = 0;
    logic [7:0] pcm = '0;
    logic [7:0] stk[$];
    logic       m_err = 1'b0;
    logic       hlt;
    logic [7:0] saved;

    pc_sequencer #(.PC_W(8), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_ack(fetch_ack), .exec_stall(exec_stall),
        .dec_jump(dec_jump), .dec_branch(dec_branch), .branch_taken(branch_taken), .dec_call(dec_call),
        .dec_ret(dec_ret), .dec_halt(dec_halt), .dec_target(dec_target), .resume(resume),
        .fetch_req(fetch_req), .pc_hold(pc_hold), .pc_jump(pc_jump), .pc_jump_line(pc_jump_line),
        .retire(retire), .halted(halted), .stack_err(stack_err)
`ifdef PCSEQ_PERF_EN
        , .perf_retired(perf_retired), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behaves as the PC register: loads on the edge that ends a cycle with pc_hold=0.
    task automatic cycle();
        logic       h, j;
        logic [7:0] l;
        h = pc_hold;
        j = pc_jump;
        l = pc_jump_line;
        @(posedge clk);
        if (reset) pcm = '0;
        else if (!h) pcm = j ? l : pcm + 8'd1;
        #1 pc_in = pcm;
    endtask

    task automatic clr();
        {dec_jump, dec_branch, branch_taken, dec_call, dec_ret, dec_halt} = '0;
        dec_target = '0;
    endtask

    task automatic chk_rst(input string tag);
        chk(tag, {fetch_req, pc_hold, pc_jump, retire, halted, stack_err, pc_jump_line},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clr();
        exec_stall = 1'b0;
        resume = 1'b0;
        fetch_ack = 1'b1;
        #2 chk_rst("reset_async");
        cycle();
        cycle();
        #2 chk_rst("reset_hold");
        reset = 1'b0;
        stk.delete();
        m_err = 1'b0;
        cycle();
        #2 chk("idle_to_fetch", {fetch_req, pcm}, {1'b1, 8'h00});
    endtask

    // One instruction from its FETCH cycle to the cycle after its final EXEC cycle.
    task automatic do_instr(input int aw, input int st, input logic j, input logic b, input logic t,
                            input logic c, input logic r, input logic h, input logic [7:0] tgt,
                            output logic ehalt);
        logic [7:0] pc0, nxt, eline;
        logic       ehold, ejump, eret;
        chk("fetch_state", {fetch_req, pc_hold, halted}, 3'b110);
        for (int w = 0; w < aw; w++) begin
            fetch_ack = 1'b0;
            cycle();
            #2 chk("fetch_wait", {fetch_req, pc_hold, retire}, 3'b110);
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'($urandom);
        for (int s = 0; s < st; s++) begin
            exec_stall = 1'b1;
            {dec_jump, dec_branch, branch_taken, dec_call, dec_ret, dec_halt} = 6'($urandom);
            dec_target = 8'($urandom);
            #2 chk("stall", {fetch_req, pc_hold, pc_jump, retire, pc_jump_line}, {4'b0100, 8'h00});
            cycle();
        end
        exec_stall = 1'b0;
        {dec_jump, dec_branch, branch_taken, dec_call, dec_ret, dec_halt} = {j, b, t, c, r, h};
        dec_target = tgt;
        pc0   = pcm;
        nxt   = pc0 + 8'd1;
        ehold = 1'b0;
        ejump = 1'b0;
        eline = '0;
        eret  = 1'b1;
        ehalt = 1'b0;
        if (h) begin
            ehold = 1'b1; nxt = pc0; ehalt = 1'b1;
        end else if (r) begin
            if (stk.size() == 0) begin
                m_err = 1'b1; ehold = 1'b1; eret = 1'b0; ehalt = 1'b1; nxt = pc0;
            end else begin
                ejump = 1'b1; eline = stk.pop_back(); nxt = eline;
            end
        end else if (c) begin
            if (stk.size() == DEPTH) begin
                m_err = 1'b1; ehold = 1'b1; eret = 1'b0; ehalt = 1'b1; nxt = pc0;
            end else begin
                stk.push_back(pc0 + 8'd1); ejump = 1'b1; eline = tgt; nxt = tgt;
            end
        end else if (j || (b && t)) begin
            ejump = 1'b1; eline = tgt; nxt = tgt;
        end
        #2 chk("final_exec", {fetch_req, pc_hold, pc_jump, retire, pc_jump_line}, {1'b0, ehold, ejump, eret, eline});
        cycle();
        clr();
        fetch_ack = 1'b1;
        #2 chk("next_pc", pcm, nxt);
        chk("next_state", {halted, fetch_req, stack_err}, {ehalt, !ehalt, m_err});
    endtask

    task automatic after_halt();
        if (!m_err) begin
            resume = 1'b1;
            cycle();
            resume = 1'b0;
            #2 chk("resume", {fetch_req, halted, pc_hold}, 3'b101);
        end else begin
            resume = 1'b1;
            cycle();
            cycle();
            resume = 1'b0;
            #2 chk("resume_blocked", {halted, stack_err, fetch_req}, 3'b110);
            do_reset();
        end
    endtask

    initial begin
        cycle();
        cycle();
        #2 chk_rst("reset");
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            #2 chk("basic_retire", {retire, pc_jump}, {(i % 2 == 0), 1'b0});
        end
        cycle();
        #2 chk("basic_pc5", {fetch_req, pcm}, {1'b1, 8'h05});

        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'h40, hlt);
        chk("jump_40", pcm, 8'h40);
        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'h05, hlt);
        do_instr(0, 0, 0, 1, 0, 0, 0, 0, 8'h10, hlt);
        chk("branch_not_taken", pcm, 8'h06);
        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'h05, hlt);
        do_instr(0, 0, 0, 1, 1, 0, 0, 0, 8'h10, hlt);
        chk("branch_taken", pcm, 8'h10);

        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'h20, hlt);
        do_instr(0, 0, 0, 0, 0, 1, 0, 0, 8'h80, hlt);
        chk("call_80", pcm, 8'h80);
        do_instr(1, 0, 0, 0, 0, 0, 1, 0, 8'h00, hlt);
        chk("ret_21", {pcm, stack_err}, {8'h21, 1'b0});

        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'hFF, hlt);
        do_instr(0, 0, 0, 0, 0, 1, 0, 0, 8'h33, hlt);
        do_instr(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, hlt);
        chk("ret_wrap", pcm, 8'h00);

        do_reset();
        for (int i = 0; i < 5; i++) do_instr(0, 0, 0, 0, 0, 1, 0, 0, 8'h30 + 8'(i), hlt);
        chk("overflow", {halted, stack_err}, 2'b11);
        after_halt();
        do_instr(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, hlt);
        chk("underflow", {halted, stack_err}, 2'b11);
        after_halt();

        do_instr(0, 0, 1, 0, 0, 0, 0, 0, 8'h55, hlt);
        saved = pcm;
        do_instr(0, 3, 0, 0, 0, 0, 0, 1, 8'h00, hlt);
        chk("halt_pc", {halted, pcm}, {1'b1, saved});
        after_halt();
        chk("resume_pc", pcm, saved);

        fetch_ack = 1'b1;
        cycle();
        exec_stall = 1'b1;
        #2 chk("midstall_1", {pc_hold, retire, fetch_req}, 3'b100);
        cycle();
        #2 chk("midstall_2", {pc_hold, retire, fetch_req}, 3'b100);
        do_reset();
        chk("reset_pc", pcm, 8'h00);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] f;
            int         op;
            f  = 6'($urandom);
            op = $urandom_range(0, 99);
            do_instr($urandom_range(0, 2), $urandom_range(0, 2), f[0], f[1], f[2], f[3] & (op < 40),
                     f[4] & (op >= 30 && op < 60), op >= 95, 8'($urandom), hlt);
            if (hlt) after_halt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
